// File: rtl/rt_pkg.sv
// Shared types and constants for the remote-terminal message controller.
package rt_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned WORDS_PER_SA = 32;
  localparam int unsigned CNT_W        = 6;
  localparam logic [4:0]  BROADCAST_ADDR = 5'd31;

  // Status word layout: terminal address in [15:11], message error in [10]
  localparam int unsigned STS_ADDR_LSB = 11;
  localparam int unsigned STS_ERR_BIT  = 10;

  typedef enum logic [2:0] {
    IDLE, DECODE, RX_WAIT, RX_SAVE, ST_LOAD, ST_SEND, TX_LOAD, TX_SEND
  } rt_state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic       tr;
    logic [4:0] sa;
    logic [4:0] n;
  } rt_cmd_t;

  function automatic logic [WORD_W-1:0] status_word(input logic [4:0] addr, input logic err);
    logic [WORD_W-1:0] w;
    w = '0;
    w[STS_ADDR_LSB +: 5] = addr;
    w[STS_ERR_BIT]       = err;
    return w;
  endfunction

endpackage

// File: rtl/rt_buf.sv
// Subaddress buffer: NUM_SA*32 x 16 dual-port RAM, linear address {sa, word}.
// The RT port wins when both ports write the same location in one cycle.
module rt_buf
  import rt_pkg::*;
#(
  parameter int unsigned NUM_SA = 4
) (
  input  logic              clk,
  input  logic              i_rt_we,
  input  logic [9:0]        i_rt_addr,
  input  logic [WORD_W-1:0] i_rt_wdata,
  output logic [WORD_W-1:0] o_rt_rdata,
  input  logic              i_host_we,
  input  logic [9:0]        i_host_addr,
  input  logic [WORD_W-1:0] i_host_wdata,
  output logic [WORD_W-1:0] o_host_rdata
);

  localparam int unsigned DEPTH = NUM_SA * WORDS_PER_SA;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic w_rt_in;
  logic w_host_in;
  logic w_host_wr;

  assign w_rt_in   = 32'(i_rt_addr) < DEPTH;
  assign w_host_in = 32'(i_host_addr) < DEPTH;
  assign w_host_wr = i_host_we && w_host_in && !(i_rt_we && (i_rt_addr == i_host_addr));

  always_ff @(posedge clk) begin
    if (i_rt_we && w_rt_in) r_mem[AW'(i_rt_addr)] <= i_rt_wdata;
    if (w_host_wr) r_mem[AW'(i_host_addr)] <= i_host_wdata;
    o_rt_rdata   <= w_rt_in   ? r_mem[AW'(i_rt_addr)]   : '0;
    o_host_rdata <= w_host_in ? r_mem[AW'(i_host_addr)] : '0;
  end

endmodule

// File: rtl/rt_msg_ctrl.sv
// Remote-terminal message controller: command decode, receive/transmit sequencing,
// status generation and word timeout. Define RT_BROADCAST_EN to accept address 31.
module rt_msg_ctrl
  import rt_pkg::*;
#(
  parameter logic [4:0]  ADDRESS = 5'd1,
  parameter int unsigned NUM_SA  = 4,
  parameter logic [15:0] TIMEOUT = 16'd400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_strobe,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        p_error,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  input  logic        tx_done,
  input  logic [4:0]  host_sa,
  input  logic [4:0]  host_addr,
  input  logic        host_we,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        busy,
  output logic        msg_err,
  output logic        timeout_pulse
);

  rt_state_e          r_state, w_nxt_state;
  logic               r_tr, w_nxt_tr;
  logic [4:0]         r_sa, w_nxt_sa;
  logic [CNT_W-1:0]   r_n, w_nxt_n;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [15:0]        r_tmo, w_nxt_tmo;
  logic               r_bcast, w_nxt_bcast;
  logic               r_phase, w_nxt_phase;
  logic [WORD_W-1:0]  r_rx_word, w_nxt_rx_word;
  logic [WORD_W-1:0]  r_tx_data, w_nxt_tx_data;
  logic               r_tx_cd, w_nxt_tx_cd;
  logic               r_tx_ready, w_nxt_tx_ready;
  logic               r_msg_err, w_nxt_msg_err;
  logic               r_tmo_pulse, w_nxt_tmo_pulse;
  logic               r_busy;

  rt_cmd_t            w_cmd;
  logic [CNT_W-1:0]   w_cmd_n;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_bc;
  logic               w_accept;
  logic               w_tmo_hit;
  logic               w_rt_we;
  logic [WORD_W-1:0]  w_rt_rdata;

  assign w_cmd     = rt_cmd_t'(rx_data);
  assign w_cmd_n   = (w_cmd.n == 5'd0) ? CNT_W'(WORDS_PER_SA) : CNT_W'(w_cmd.n);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tmo_hit = (r_tmo == TIMEOUT - 16'd1);
  assign w_rt_we   = (r_state == RX_SAVE);

`ifdef RT_BROADCAST_EN
  assign w_bc = (w_cmd.addr == BROADCAST_ADDR) && !w_cmd.tr;
`else
  assign w_bc = 1'b0;
`endif

  assign w_accept = (32'(w_cmd.sa) < NUM_SA) && ((w_cmd.addr == ADDRESS) || w_bc);

  rt_buf #(.NUM_SA(NUM_SA)) u_buf (
    .clk          (clk),
    .i_rt_we      (w_rt_we),
    .i_rt_addr    ({r_sa, r_cnt[4:0]}),
    .i_rt_wdata   (r_rx_word),
    .o_rt_rdata   (w_rt_rdata),
    .i_host_we    (host_we),
    .i_host_addr  ({host_sa, host_addr}),
    .i_host_wdata (host_wdata),
    .o_host_rdata (host_rdata)
  );

  // Next-state and registered-output logic; a command strobe overrides any state
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_tr        = r_tr;
    w_nxt_sa        = r_sa;
    w_nxt_n         = r_n;
    w_nxt_cnt       = r_cnt;
    w_nxt_tmo       = r_tmo;
    w_nxt_bcast     = r_bcast;
    w_nxt_phase     = r_phase;
    w_nxt_rx_word   = r_rx_word;
    w_nxt_tx_data   = r_tx_data;
    w_nxt_tx_cd     = r_tx_cd;
    w_nxt_tx_ready  = 1'b0;
    w_nxt_msg_err   = r_msg_err;
    w_nxt_tmo_pulse = 1'b0;
    if (cmd_strobe) begin
      if (w_accept) begin
        w_nxt_state   = DECODE;
        w_nxt_tr      = w_cmd.tr;
        w_nxt_sa      = w_cmd.sa;
        w_nxt_n       = w_cmd_n;
        w_nxt_cnt     = '0;
        w_nxt_bcast   = w_bc && (w_cmd.addr != ADDRESS);
        w_nxt_msg_err = p_error;
      end else begin
        w_nxt_state = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: ;
        DECODE: begin
          w_nxt_tmo   = '0;
          w_nxt_state = r_tr ? ST_LOAD : RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_done) begin
            w_nxt_rx_word = rx_data;
            if (p_error) w_nxt_msg_err = 1'b1;
            w_nxt_state = RX_SAVE;
          end else if (w_tmo_hit) begin
            w_nxt_state     = IDLE;
            w_nxt_msg_err   = 1'b1;
            w_nxt_tmo_pulse = 1'b1;
          end else begin
            w_nxt_tmo = r_tmo + 16'd1;
          end
        end
        RX_SAVE: begin
          w_nxt_cnt = w_cnt_inc;
          if (w_cnt_inc == r_n) begin
            w_nxt_state = r_bcast ? IDLE : ST_LOAD;
          end else begin
            w_nxt_state = RX_WAIT;
            w_nxt_tmo   = '0;
          end
        end
        ST_LOAD: begin
          w_nxt_tx_data  = status_word(ADDRESS, r_msg_err);
          w_nxt_tx_cd    = 1'b0;
          w_nxt_tx_ready = 1'b1;
          w_nxt_tmo      = '0;
          w_nxt_state    = ST_SEND;
        end
        ST_SEND: begin
          if (tx_done) begin
            w_nxt_cnt   = '0;
            w_nxt_phase = 1'b0;
            w_nxt_state = r_tr ? TX_LOAD : IDLE;
          end else if (w_tmo_hit) begin
            w_nxt_state     = IDLE;
            w_nxt_msg_err   = 1'b1;
            w_nxt_tmo_pulse = 1'b1;
          end else begin
            w_nxt_tmo = r_tmo + 16'd1;
          end
        end
        // Phase 0 presents the read address, phase 1 has the RAM word
        TX_LOAD: begin
          if (!r_phase) begin
            w_nxt_phase = 1'b1;
          end else begin
            w_nxt_phase    = 1'b0;
            w_nxt_tx_data  = w_rt_rdata;
            w_nxt_tx_cd    = 1'b1;
            w_nxt_tx_ready = 1'b1;
            w_nxt_tmo      = '0;
            w_nxt_state    = TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_done) begin
            w_nxt_cnt   = w_cnt_inc;
            w_nxt_phase = 1'b0;
            w_nxt_state = (w_cnt_inc == r_n) ? IDLE : TX_LOAD;
          end else if (w_tmo_hit) begin
            w_nxt_state     = IDLE;
            w_nxt_msg_err   = 1'b1;
            w_nxt_tmo_pulse = 1'b1;
          end else begin
            w_nxt_tmo = r_tmo + 16'd1;
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tr        <= 1'b0;
      r_sa        <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_bcast     <= 1'b0;
      r_phase     <= 1'b0;
      r_rx_word   <= '0;
      r_tx_data   <= '0;
      r_tx_cd     <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_msg_err   <= 1'b0;
      r_tmo_pulse <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_tr        <= w_nxt_tr;
      r_sa        <= w_nxt_sa;
      r_n         <= w_nxt_n;
      r_cnt       <= w_nxt_cnt;
      r_tmo       <= w_nxt_tmo;
      r_bcast     <= w_nxt_bcast;
      r_phase     <= w_nxt_phase;
      r_rx_word   <= w_nxt_rx_word;
      r_tx_data   <= w_nxt_tx_data;
      r_tx_cd     <= w_nxt_tx_cd;
      r_tx_ready  <= w_nxt_tx_ready;
      r_msg_err   <= w_nxt_msg_err;
      r_tmo_pulse <= w_nxt_tmo_pulse;
      r_busy      <= (w_nxt_state != IDLE);
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_cd         = r_tx_cd;
  assign tx_ready      = r_tx_ready;
  assign busy          = r_busy;
  assign msg_err       = r_msg_err;
  assign timeout_pulse = r_tmo_pulse;

endmodule

// File: doc/rt_msg_ctrl.md
RT_MSG_CTRL -- requirements
Module: rt_msg_ctrl

Interface
REQ-001 Param ADDRESS, default 5'd1, remote terminal address.
REQ-002 Param NUM_SA, default 4, number of implemented subaddresses (1..30), each a 32 x 16 buffer.
REQ-003 Param TIMEOUT, default 16'd400, clk cycles allowed between expected data words.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cmd_strobe  in  1  one-cycle pulse: rx_data holds a decoded command word.
REQ-007 rx_done  in  1  one-cycle pulse: rx_data holds a data word.
REQ-008 rx_data  in  16  received word from decoder.
REQ-009 p_error  in  1  parity error, qualified by rx_done or cmd_strobe.
REQ-010 tx_data  out  16  word to encoder; tx_cd  out  1  0 = status word, 1 = data word.
REQ-011 tx_ready  out  1  one-cycle start-of-transmit pulse; tx_done  in  1  encoder finished current word.
REQ-012 host_sa  in  5, host_addr  in  5, host_we  in  1, host_wdata  in  16, host_rdata  out  16  host buffer port, 1-cycle read latency.
REQ-013 busy  out  1  message in progress; msg_err  out  1  sticky parity/timeout flag of last message; timeout_pulse  out  1.

Function
REQ-014 Command decode: RT addr = rx_data[15:11], T/R = rx_data[10], SA = rx_data[9:5], N = rx_data[4:0], N = 0 means 32; word counter 6 bits.
REQ-015 States: IDLE, DECODE, RX_WAIT, RX_SAVE, ST_LOAD, ST_SEND, TX_LOAD, TX_SEND.
REQ-016 IDLE: on cmd_strobe with addr == ADDRESS and SA < NUM_SA -> DECODE next cycle, busy = 1, msg_err cleared (set if p_error); otherwise stay IDLE.
REQ-017 DECODE: T/R = 0 -> RX_WAIT; T/R = 1 -> ST_LOAD.
REQ-018 RX_WAIT: rx_done -> RX_SAVE; buffer[SA][cnt] written with rx_data in RX_SAVE; p_error sets msg_err; cnt increments; cnt == N -> ST_LOAD else RX_WAIT.
REQ-019 Timeout: counter reloads on entry to RX_WAIT/ST_SEND/TX_SEND; reaching TIMEOUT -> IDLE, msg_err = 1, timeout_pulse one cycle, no status word sent.
REQ-020 ST_LOAD: tx_data = {ADDRESS, msg_err, 10'd0}, tx_cd = 0, tx_ready pulse one cycle, -> ST_SEND.
REQ-021 ST_SEND: on tx_done -> TX_LOAD if T/R = 1, else IDLE.
REQ-022 TX_LOAD: read buffer[SA][cnt], 1-cycle latency; then tx_data = word, tx_cd = 1, tx_ready pulse, -> TX_SEND; on tx_done cnt increments; cnt == N -> IDLE else TX_LOAD.
REQ-023 cmd_strobe in any non-IDLE state aborts current message and is decoded as in IDLE (superseding command); partial receive words remain written.
REQ-024 host_we and RT write same cycle same location: RT write wins, host write discarded.
REQ-025 tx_ready never asserted twice without intervening tx_done.
REQ-026 busy = 0 exactly in IDLE.

Reset
REQ-027 reset low at clk edge: STATE = IDLE, tx_data = 0, tx_cd = 0, tx_ready = 0, busy = 0, msg_err = 0, timeout_pulse = 0, counters = 0; buffer contents not cleared.
REQ-028 Reset mid-message: no further tx_ready; next message starts from IDLE.

Configuration
REQ-029 Macro RT_BROADCAST_EN defined: addr 5'd31 accepted; receive-mode broadcast stores data, never enters ST_LOAD/ST_SEND (no status), returns to IDLE; transmit-mode broadcast ignored.
REQ-030 RT_BROADCAST_EN undefined: addr 5'd31 treated as non-matching.

Structure
REQ-031 Package rt_pkg holds state encoding, status-word field positions, BROADCAST_ADDR = 5'd31, WORDS_PER_SA = 32.
REQ-032 Sub-module rt_buf: single-clock dual-port RAM, NUM_SA*32 x 16, address {SA, word}, RT port write priority.

Verification
REQ-033 Receive N=3, SA=1, no errors -> buffer[1][0..2] = data, status 16'h0800 (ADDRESS=1), busy drops after tx_done.
REQ-034 Receive N=2, p_error on word 2 -> status 16'h0C00, msg_err = 1.
REQ-035 Host preloads SA=2 words 16'hA5A5, 16'h5A5A; transmit N=2 -> status, then data words with tx_cd=1 in order, one tx_ready per tx_done.
REQ-036 Receive N=4, only 2 words sent -> timeout_pulse after TIMEOUT cycles, no tx_ready, IDLE.
REQ-037 Command N=0 -> 32 words accepted before status.
REQ-038 RT_BROADCAST_EN set, receive to addr 31 N=1 -> data stored, no tx_ready; undefined -> ignored, busy stays 0.
